// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
// Multi-cycle multiply/divide controller for the 5-stage pipeline. Owns the
// HI/LO registers, models the fixed MDU latency with a down-counter FSM and
// raises the D-stage stall request while an MDU-class instruction would have
// to wait behind a busy unit.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-low; clears all state
//   start     in   E-stage MDU instruction valid
//   md_op     in   3-bit MDU opcode (see OP_* below)
//   a, b      in   forwarded rs / rt operands
//   md_use_D  in   D-stage instruction uses the MDU
//   busy      out  operation in progress (registered)
//   stall_md  out  combinational stall request to hazard logic
//   done      out  one-cycle pulse after a mult/div commit (registered)
//   hi, lo    out  HI / LO registers
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | unit free; accepts mult/div issue and mthi/mtlo writes
// MULT  | multiply in flight, counting down MULT_CYCLES
// DIV   | divide in flight, counting down DIV_CYCLES
// ---------------------------------------------------------------------------
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic [31:0]   hi_tmp_q;
    logic [31:0]   lo_tmp_q;
    logic          div_zero_q;

    logic [63:0]   prod_d;
    logic [31:0]   quo_d;
    logic [31:0]   rem_d;
    logic          is_muldiv;

    // Products are formed on operands sign- or zero-extended to 64 bits so the
    // low 64 bits of the product are exact for both mult and multu.
    always_comb begin
        prod_d = '0;
        if (md_op == OP_MULT) begin
            prod_d = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        end else begin
            prod_d = {32'b0, a} * {32'b0, b};
        end
    end

    // Divide by zero produces no result (HI/LO are left alone at commit), and
    // the single signed overflow case is pinned so it never depends on the
    // host arithmetic.
    always_comb begin
        quo_d = '0;
        rem_d = '0;
        if (b != 32'b0) begin
            if (md_op == OP_DIV) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    quo_d = 32'h8000_0000;
                    rem_d = 32'h0;
                end else begin
                    quo_d = $signed(a) / $signed(b);
                    rem_d = $signed(a) % $signed(b);
                end
            end else begin
                quo_d = a / b;
                rem_d = a % b;
            end
        end
    end

    assign is_muldiv = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                       (md_op == OP_DIV)  || (md_op == OP_DIVU);

    // Covers the issue cycle too: busy is still low then, but the younger
    // MDU instruction in D must already hold.
    assign stall_md = md_use_D & (busy_q | (start & is_muldiv));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            hi_tmp_q   <= '0;
            lo_tmp_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                hi_tmp_q   <= prod_d[63:32];
                                lo_tmp_q   <= prod_d[31:0];
                                div_zero_q <= 1'b0;
                                cnt_q      <= CW'(MULT_CYCLES);
                                busy_q     <= 1'b1;
                                state_q    <= MULT;
                            end
                            OP_DIV, OP_DIVU: begin
                                hi_tmp_q   <= rem_d;
                                lo_tmp_q   <= quo_d;
                                div_zero_q <= (b == 32'b0);
                                cnt_q      <= CW'(DIV_CYCLES);
                                busy_q     <= 1'b1;
                                state_q    <= DIV;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                MULT, DIV: begin
                    // New starts are ignored here; the hazard unit holds them.
                    if (cnt_q == CW'(1)) begin
                        if (!div_zero_q) begin
                            hi_q <= hi_tmp_q;
                            lo_q <= lo_tmp_q;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
